// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN types and helpers for the conv and pooling stages.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SCAN,
        S_STORE,
        S_DONE
    } pool_state_t;

    // Flat element index of (c,y,x) in a channel-major square map of the given side.
    function automatic int chw_idx(input int c, input int y, input int x, input int side);
        return c * side * side + y * side + x;
    endfunction

endpackage

// File: rtl/relu_maxpool.sv
// relu_maxpool: per-channel ReLU plus non-overlapping PxP max pooling,
// scanning one input element per clock after start.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int N        = 16,
    parameter int IN_SIDE  = 6,
    parameter int CHANNELS = 4,
    parameter int P        = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [N*CHANNELS*IN_SIDE*IN_SIDE-1:0]       in_mem_flat,
    output logic [N*CHANNELS*(IN_SIDE/P)*(IN_SIDE/P)-1:0] out_mem_flat,
    output logic                                        done
);

    localparam int OUT_SIDE = IN_SIDE / P;
    localparam int OW       = N * CHANNELS * OUT_SIDE * OUT_SIDE;
    localparam int CW       = $clog2(CHANNELS + 1);
    localparam int SW       = $clog2(OUT_SIDE + 1);
    localparam int PW       = $clog2(P + 1);

    pool_state_t          state_q, state_d;
    logic                 done_d, done_q;
    logic [OW-1:0]        out_d, out_q;
    logic [CW-1:0]        c_d, c_q;
    logic [SW-1:0]        oy_d, oy_q, ox_d, ox_q;
    logic [PW-1:0]        py_d, py_q, px_d, px_q;
    logic signed [N-1:0]  max_d, max_q;
    logic signed [N-1:0]  elem;
    logic                 last_px, last_py, last_ox, last_oy, last_c;

    assign elem = in_mem_flat[chw_idx(int'(c_q), int'(oy_q) * P + int'(py_q),
                                      int'(ox_q) * P + int'(px_q), IN_SIDE) * N +: N];

    assign last_px = px_q == PW'(P - 1);
    assign last_py = py_q == PW'(P - 1);
    assign last_ox = ox_q == SW'(OUT_SIDE - 1);
    assign last_oy = oy_q == SW'(OUT_SIDE - 1);
    assign last_c  = c_q == CW'(CHANNELS - 1);

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        out_d   = out_q;
        c_d     = c_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        py_d    = py_q;
        px_d    = px_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    c_d     = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    py_d    = '0;
                    px_d    = '0;
                    max_d   = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                max_d   = '0;
                py_d    = '0;
                px_d    = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                max_d   = (elem > max_q) ? elem : max_q;
                px_d    = last_px ? '0 : px_q + 1'b1;
                py_d    = last_px ? (last_py ? '0 : py_q + 1'b1) : py_q;
                state_d = (last_px && last_py) ? S_STORE : S_SCAN;
            end
            S_STORE: begin
                out_d[chw_idx(int'(c_q), int'(oy_q), int'(ox_q), OUT_SIDE) * N +: N] = max_q;
                ox_d    = last_ox ? '0 : ox_q + 1'b1;
                oy_d    = last_ox ? (last_oy ? '0 : oy_q + 1'b1) : oy_q;
                c_d     = (last_ox && last_oy) ? (last_c ? '0 : c_q + 1'b1) : c_q;
                state_d = (last_ox && last_oy && last_c) ? S_DONE : S_INIT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = start ? S_DONE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            out_q   <= '0;
            c_q     <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            py_q    <= '0;
            px_q    <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            out_q   <= out_d;
            c_q     <= c_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            py_q    <= py_d;
            px_q    <= px_d;
            max_q   <= max_d;
        end
    end

    assign out_mem_flat = out_q;
    assign done         = done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed scoreboard bench for relu_maxpool with default parameters.
module tb_relu_maxpool;
    import cnn_pkg::*;

    localparam int N = 16, S = 6, C = 4, P = 2, OS = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [N*C*S*S-1:0]      in_mem_flat = '0;
    logic [N*C*OS*OS-1:0]    out_mem_flat;
    logic                    done;

    logic signed [15:0] mem [C][S][S];

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    relu_maxpool dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_mem_flat(in_mem_flat),
        .out_mem_flat(out_mem_flat),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] slot(input int c, input int oy, input int ox);
        return out_mem_flat[((c * OS + oy) * OS + ox) * N +: N];
    endfunction

    task automatic fill(input logic signed [15:0] v);
        for (int c = 0; c < C; c++)
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++)
                    mem[c][y][x] = v;
    endtask

    task automatic pack();
        for (int c = 0; c < C; c++)
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++)
                    in_mem_flat[((c * S + y) * S + x) * N +: N] = mem[c][y][x];
    endtask

    // Reference: max over each window, seeded at zero so negatives clip.
    task automatic push_expected();
        logic signed [15:0] m;
        for (int c = 0; c < C; c++)
            for (int oy = 0; oy < OS; oy++)
                for (int ox = 0; ox < OS; ox++) begin
                    m = 0;
                    for (int wy = 0; wy < P; wy++)
                        for (int wx = 0; wx < P; wx++)
                            if (mem[c][oy*P+wy][ox*P+wx] > m) m = mem[c][oy*P+wy][ox*P+wx];
                    sb.push_back('{(c * OS + oy) * OS + ox, m});
                end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_slot%0d", tag, e.idx), 32'(out_mem_flat[e.idx*N +: N]), 32'(e.val));
        end
    endtask

    task automatic run(input bit hold, input string tag);
        int cnt;
        pack();
        push_expected();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        cnt = 0;
        while (!done && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd217);
        drain(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out_any", 32'(|out_mem_flat), 32'd0);

        fill(0);
        for (int y = 0; y < S; y++)
            for (int x = 0; x < S; x++)
                mem[0][y][x] = 16'(y * 6 + x);
        run(1'b0, "ramp");
        chk("ramp_000", 32'(slot(0, 0, 0)), 32'd7);
        chk("ramp_001", 32'(slot(0, 0, 1)), 32'd9);
        chk("ramp_022", 32'(slot(0, 2, 2)), 32'd35);
        chk("ramp_c1_00", 32'(slot(1, 0, 0)), 32'd0);

        fill(-16'sd256);
        run(1'b0, "neg");
        chk("neg_any", 32'(|out_mem_flat), 32'd0);

        fill(-16'sd256);
        mem[3][5][4] = 16'sh0180;
        run(1'b0, "single");
        chk("single_322", 32'(slot(3, 2, 2)), 32'h0180);

        fill(0);
        mem[1][0][0] = 16'sd5;
        mem[1][0][1] = -16'sd3;
        mem[1][1][0] = 16'sd2;
        mem[1][1][1] = 16'sh7FFF;
        run(1'b0, "lastelem");
        chk("lastelem_100", 32'(slot(1, 0, 0)), 32'h7FFF);

        for (int c = 0; c < C; c++)
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++)
                    mem[c][y][x] = 16'($urandom_range(0, 65535));
        pack();
        push_expected();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        sb.delete();
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_out_any", 32'(|out_mem_flat), 32'd0);
        chk("midreset_state", 32'(dut.state_q), 32'(S_IDLE));
        run(1'b0, "restart");

        for (int c = 0; c < C; c++)
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++)
                    mem[c][y][x] = 16'($urandom_range(0, 65535));
        run(1'b1, "hold");
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done_stays", 32'(done), 32'd1);
        chk("hold_state", 32'(dut.state_q), 32'(S_DONE));
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_done_still", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("drop_done_falls", 32'(done), 32'd0);

        for (int c = 0; c < C; c++)
            for (int y = 0; y < S; y++)
                for (int x = 0; x < S; x++)
                    mem[c][y][x] = 16'($urandom_range(0, 65535));
        run(1'b0, "second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
